// File: rtl/dev_board_gpio_pkg.sv
// Shared width defaults for the dev-board GPIO wrapper and its CPU-side interface.
package dev_board_gpio_pkg;
    localparam int LED_W_DEF = 8;
    localparam int SW_W_DEF  = 4;
endpackage

// File: rtl/dev_board_gpio_if.sv
// CPU-side GPIO bus: write strobe and data toward the LED latch, read strobe and switch readback.
interface dev_board_gpio_if
    import dev_board_gpio_pkg::*;
#(
    parameter int LED_W = LED_W_DEF,
    parameter int SW_W  = SW_W_DEF
);
    logic             RD_GPIO;
    logic             WR_GPIO;
    logic [LED_W-1:0] GPO;
    logic [SW_W-1:0]  GPI;

    modport master (
        output RD_GPIO,
        output WR_GPIO,
        output GPO,
        input  GPI
    );

    modport slave (
        input  RD_GPIO,
        input  WR_GPIO,
        input  GPO,
        output GPI
    );
endinterface

// File: rtl/dev_board_gpio_reset_sync.sv
// Two-flop reset synchronizer: asserts with rst_n asynchronously, releases on the second clean edge.
module dev_board_gpio_reset_sync (
    input  logic clk,
    input  logic rst_n,
    output logic rst_out
);
    logic meta_reg;
    logic sync_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b1;
            sync_reg <= 1'b1;
        end else begin
            meta_reg <= 1'b0;
            sync_reg <= meta_reg;
        end
    end

    assign rst_out = sync_reg;
endmodule

// File: rtl/dev_board_gpio.sv
// Board GPIO wrapper: LED output latch, registered DIP switch readback, clock and reset fan-out.
module dev_board_gpio
    import dev_board_gpio_pkg::*;
#(
    parameter int LED_W = LED_W_DEF,
    parameter int SW_W  = SW_W_DEF
) (
    input  logic              CLK_X1,
    input  logic              RESETN,
    input  logic [SW_W-1:0]   DIPSW,
    output logic [LED_W-1:0]  LED,
    output logic              CLK,
    output logic              RESET,
    dev_board_gpio_if.slave   cpu
);
    logic [LED_W-1:0] led_reg;
    logic [SW_W-1:0]  gpi_reg;

    // Latch and GPI use the raw board reset so a write on the very first edge after release lands.
    always_ff @(posedge CLK_X1 or negedge RESETN) begin
        if (!RESETN) begin
            led_reg <= '0;
        end else if (cpu.WR_GPIO) begin
            led_reg <= cpu.GPO;
        end
    end

    always_ff @(posedge CLK_X1 or negedge RESETN) begin
        if (!RESETN) begin
            gpi_reg <= '0;
        end else begin
            gpi_reg <= DIPSW;
        end
    end

    dev_board_gpio_reset_sync u_reset_sync (
        .clk     (CLK_X1),
        .rst_n   (RESETN),
        .rst_out (RESET)
    );

    // Reads carry no side effects; the strobe is accepted but intentionally unused.
    logic unused_rd;
    assign unused_rd = cpu.RD_GPIO;

    assign LED     = led_reg;
    assign cpu.GPI = gpi_reg;
    assign CLK     = CLK_X1;
endmodule

// File: tb/tb_dev_board_gpio.sv
// Directed bench for dev_board_gpio with a queue-based scoreboard of expected LED/GPI/RESET values.
module tb_dev_board_gpio;
    logic       CLK_X1;
    logic       RESETN;
    logic [3:0] DIPSW;
    logic [7:0] LED;
    logic       CLK;
    logic       RESET;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      tag;
        logic [7:0] led;
        logic [3:0] gpi;
        logic       rst;
    } exp_t;

    exp_t sb_q[$];

    dev_board_gpio_if #(.LED_W(8), .SW_W(4)) bus ();

    dev_board_gpio #(.LED_W(8), .SW_W(4)) dut (
        .CLK_X1 (CLK_X1),
        .RESETN (RESETN),
        .DIPSW  (DIPSW),
        .LED    (LED),
        .CLK    (CLK),
        .RESET  (RESET),
        .cpu    (bus.slave)
    );

    initial CLK_X1 = 1'b0;
    always #5 CLK_X1 = ~CLK_X1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic [7:0] led, input logic [3:0] gpi, input logic rst);
        exp_t e;
        e.tag = tag;
        e.led = led;
        e.gpi = gpi;
        e.rst = rst;
        sb_q.push_back(e);
    endtask

    // Advance one edge, pop the oldest expectation and compare; also check CLK in both phases.
    task automatic step();
        exp_t e;
        @(posedge CLK_X1);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e = sb_q.pop_front();
            chk({e.tag, "_led"}, {24'd0, LED}, {24'd0, e.led});
            chk({e.tag, "_gpi"}, {28'd0, bus.GPI}, {28'd0, e.gpi});
            chk({e.tag, "_rst"}, {31'd0, RESET}, {31'd0, e.rst});
            $display("step %s led=%02h gpi=%1h reset=%0b", e.tag, LED, bus.GPI, RESET);
        end
        chk("clk_high", {31'd0, CLK}, {31'd0, CLK_X1});
        #5;
        chk("clk_low", {31'd0, CLK}, {31'd0, CLK_X1});
    endtask

    initial begin
        logic [7:0] walk;
        logic [3:0] sw;

        RESETN      = 1'b0;
        DIPSW       = 4'h5;
        bus.RD_GPIO = 1'b0;
        bus.WR_GPIO = 1'b1;
        bus.GPO     = 8'h01;

        // Writes and switch sampling are ignored while reset is held.
        push("in_reset_1", 8'h00, 4'h0, 1'b1);
        step();
        push("in_reset_2", 8'h00, 4'h0, 1'b1);
        step();

        DIPSW  = 4'h0;
        RESETN = 1'b1;
        push("release_e1", 8'h01, 4'h0, 1'b1);
        step();

        walk = 8'h02;
        for (int i = 0; i < 7; i++) begin
            bus.GPO = walk;
            push($sformatf("walk_gpo_%0d", i), walk, 4'h0, 1'b0);
            step();
            walk = walk << 1;
        end

        bus.WR_GPIO = 1'b0;
        sw = 4'h1;
        for (int i = 0; i < 4; i++) begin
            DIPSW = sw;
            push($sformatf("walk_sw_%0d", i), 8'h80, sw, 1'b0);
            step();
            sw = sw << 1;
        end
        push("sw_hold", 8'h80, 4'h8, 1'b0);
        step();

        bus.RD_GPIO = 1'b1;
        push("rd_only", 8'h80, 4'h8, 1'b0);
        step();
        bus.WR_GPIO = 1'b1;
        bus.GPO     = 8'h55;
        push("wr_and_rd", 8'h55, 4'h8, 1'b0);
        step();
        bus.RD_GPIO = 1'b0;

        bus.WR_GPIO = 1'b0;
        bus.GPO     = 8'hAA;
        push("wr_low_hold", 8'h55, 4'h8, 1'b0);
        step();
        bus.WR_GPIO = 1'b1;
        push("wr_pulse", 8'hAA, 4'h8, 1'b0);
        step();
        bus.WR_GPIO = 1'b0;
        bus.GPO     = 8'h0F;
        push("after_pulse", 8'hAA, 4'h8, 1'b0);
        step();

        // Mid-run reset must clear everything without waiting for an edge.
        DIPSW  = 4'h3;
        RESETN = 1'b0;
        #1;
        chk("async_led", {24'd0, LED}, 32'h0);
        chk("async_gpi", {28'd0, bus.GPI}, 32'h0);
        chk("async_rst", {31'd0, RESET}, 32'h1);
        $display("async_reset led=%02h gpi=%1h reset=%0b", LED, bus.GPI, RESET);

        bus.WR_GPIO = 1'b1;
        push("midrst_wr", 8'h00, 4'h0, 1'b1);
        step();

        bus.WR_GPIO = 1'b0;
        RESETN      = 1'b1;
        push("rerelease_e1", 8'h00, 4'h3, 1'b1);
        step();
        push("rerelease_e2", 8'h00, 4'h3, 1'b0);
        step();

        if (sb_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
